// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM responder with valid/ready channels and programmable wait states.
// Optional range checking of address bits [31:AW] is enabled with DMEM_RANGE_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH = 1024,
  parameter int AW = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] txn_count
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d, err_q, err_d, rsp_err_q, rsp_err_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [15:0] txn_q, txn_d;
  logic [31:0] mem [DEPTH];
  logic accept, commit, c_we, c_bad, bad_in, mem_we;
  logic [AW-1:0] c_idx;
  logic [31:0] c_wdata;
`ifdef DMEM_RANGE_CHECK_EN
  assign bad_in = |req_addr[31:AW];
`else
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW];
  assign bad_in = 1'b0;
`endif
  // Ready drops combinationally with rst so nothing is accepted during reset.
  assign req_ready = ~rst & (state_q == IDLE);
  assign accept = req_valid & req_ready;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err = rsp_err_q;
  assign txn_count = txn_q;
  always_comb begin
    c_we = (state_q == IDLE) ? req_we : we_q;
    c_idx = (state_q == IDLE) ? req_addr[AW-1:0] : idx_q;
    c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    c_bad = (state_q == IDLE) ? bad_in : err_q;
    commit = (accept && WC == 4'd0) || (state_q == WAIT && cnt_q == 4'd1);
    mem_we = commit & c_we & ~c_bad;
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    err_d = err_q;
    rdata_d = rdata_q;
    rsp_err_d = rsp_err_q;
    txn_d = txn_q;
    if (accept) begin
      we_d = req_we;
      idx_d = req_addr[AW-1:0];
      wdata_d = req_wdata;
      err_d = bad_in;
      cnt_d = WC;
      state_d = (WC == 4'd0) ? RESP : WAIT;
    end
    if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
      state_d = (cnt_q == 4'd1) ? RESP : WAIT;
    end
    if (commit) begin
      rdata_d = c_we ? 32'h0 : c_bad ? 32'hDEADBEEF : mem[c_idx];
      rsp_err_d = c_bad;
    end
    if (rsp_valid && rsp_ready) begin
      state_d = IDLE;
      rsp_err_d = 1'b0;
      txn_d = txn_q + 16'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      idx_q <= '0;
      wdata_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
      rsp_err_q <= 1'b0;
      txn_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      rsp_err_q <= rsp_err_d;
      txn_q <= txn_d;
    end
  end
  // Array is deliberately outside the reset domain; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[c_idx] <= c_wdata;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a word-array reference model.
module tb_dmem_responder;
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic sel = 1'b0, req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic a_ready, a_valid, a_err, b_ready, b_valid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [15:0] a_txn, b_txn;
  logic o_ready, o_valid, o_err;
  logic [31:0] o_rdata;
  logic [15:0] o_txn;
  logic [31:0] ma [int];
  logic [31:0] mb [int];
  int cnt [2];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(a_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_valid), .rsp_ready(rsp_ready & ~sel), .rsp_rdata(a_rdata),
    .rsp_err(a_err), .txn_count(a_txn));
  dmem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(b_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_valid), .rsp_ready(rsp_ready & sel), .rsp_rdata(b_rdata),
    .rsp_err(b_err), .txn_count(b_txn));
  assign o_ready = sel ? b_ready : a_ready;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_err = sel ? b_err : a_err;
  assign o_rdata = sel ? b_rdata : a_rdata;
  assign o_txn = sel ? b_txn : a_txn;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic txn(input bit s, input bit we, input logic [31:0] addr, input logic [31:0] wd, input int hold);
    logic [31:0] er;
    bit bad;
    int n;
    bad = RC && (addr >= 32'd1024);
    if (we) er = 32'h0;
    else if (bad) er = 32'hDEADBEEF;
    else er = s ? mb[int'(addr % 1024)] : ma[int'(addr % 1024)];
    if (we && !bad) begin
      if (s) mb[int'(addr % 1024)] = wd;
      else ma[int'(addr % 1024)] = wd;
    end
    @(negedge clk);
    sel = s; req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; rsp_ready = 1'b0;
    #1 chk("req_ready_idle", {31'b0, o_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 1;
    while (!o_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", n, s ? 32'd1 : 32'd3);
    repeat (hold) begin
      chk("hold_valid", {31'b0, o_valid}, 32'd1);
      chk("hold_rdata", o_rdata, er);
      chk("hold_ready", {31'b0, o_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("rdata", o_rdata, er);
    chk("err", {31'b0, o_err}, {31'b0, bad});
    chk("ready_in_resp", {31'b0, o_ready}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    cnt[s] = (cnt[s] + 1) % 65536;
    chk("valid_drop", {31'b0, o_valid}, 32'd0);
    chk("txn_count", {16'b0, o_txn}, cnt[s]);
  endtask
  initial begin
    cnt[0] = 0; cnt[1] = 0;
    #12;
    chk("rst_ready", {31'b0, a_ready}, 32'd0);
    chk("rst_valid", {31'b0, a_valid}, 32'd0);
    chk("rst_txn", {16'b0, a_txn}, 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_err", {31'b0, a_err}, 32'd0);
    @(negedge clk) rst = 1'b0;
    #1 chk("post_rst_ready", {31'b0, a_ready}, 32'd1);
    txn(0, 1, 32'd5, 32'h0000001E, 0);
    txn(0, 0, 32'd5, 32'h0, 0);
    chk("txn_two", {16'b0, a_txn}, 32'd2);
    txn(0, 0, 32'd5, 32'h0, 6);
    for (int i = 0; i < 4; i++) txn(1, 1, i, $urandom, 0);
    for (int i = 0; i < 4; i++) txn(1, 0, i, 32'h0, 0);
    for (int i = 0; i < 16; i++) txn(0, 1, i, $urandom, 0);
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      a = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom << 10);
      txn(0, 1'($urandom), a, $urandom, $urandom_range(0, 3));
    end
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd9; req_wdata = 32'd7;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    #1 chk("midrst_valid", {31'b0, a_valid}, 32'd0);
    chk("midrst_ready", {31'b0, a_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 chk("midrst_ready_after", {31'b0, a_ready}, 32'd1);
    chk("midrst_txn", {16'b0, a_txn}, 32'd0);
    cnt[0] = 0; cnt[1] = 0;
    txn(0, 0, 32'd9, 32'h0, 0);
    if (RC) begin
      txn(0, 1, 32'h400, 32'h12345678, 0);
      txn(0, 0, 32'h400, 32'h0, 0);
      txn(0, 0, 32'h0, 32'h0, 0);
    end else begin
      txn(0, 0, 32'h400, 32'h0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
